// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single-ported RAM to the dcache (priority) or the icache, word at a time.
// Define MEM_ARB_FAIR_EN to add a counter that forces an icache turn after MAX_DGRANTS dcache words.
module mem_arbiter #(
  parameter int MAX_DGRANTS = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ram_err
);
  // state  | meaning
  // IDLE   | no owner, RAM enables low
  // DGRANT | dcache owns the RAM port
  // IGRANT | icache owns the RAM port
  typedef enum logic [1:0] {IDLE = 2'd0, DGRANT = 2'd1, IGRANT = 2'd2} owner_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  owner_t owner;
  logic   d_req;
  logic   d_done;
  logic   i_done;
  logic   fair_hit;

  assign d_req  = dREN | dWEN;
  assign d_done = (owner == DGRANT) && (ramstate == RAM_ACCESS);
  assign i_done = (owner == IGRANT) && (ramstate == RAM_ACCESS);

`ifdef MEM_ARB_FAIR_EN
  logic [3:0] fair_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      fair_cnt <= '0;
    else if (!iREN || i_done)
      fair_cnt <= '0;
    else if (d_done)
      fair_cnt <= fair_cnt + 4'd1;
  end

  // This completion is the MAX_DGRANTS-th in a row with the icache waiting.
  assign fair_hit = d_done && iREN && (fair_cnt == 4'(MAX_DGRANTS - 1));
`else
  logic unused_max;
  assign unused_max = (MAX_DGRANTS == 0);
  assign fair_hit   = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      owner   <= IDLE;
      ram_err <= 1'b0;
    end else begin
      if ((owner != IDLE) && (ramstate == RAM_ERROR))
        ram_err <= 1'b1;
      case (owner)
        DGRANT: begin
          if (d_req)
            owner <= fair_hit ? IGRANT : DGRANT;
          else
            owner <= iREN ? IGRANT : IDLE;
        end
        IGRANT: begin
          if (iREN)
            owner <= (i_done && d_req) ? DGRANT : IGRANT;
          else
            owner <= d_req ? DGRANT : IDLE;
        end
        default: begin
          if (d_req)
            owner <= DGRANT;
          else if (iREN)
            owner <= IGRANT;
          else
            owner <= IDLE;
        end
      endcase
    end
  end

  // RAM side follows the registered owner; a read+write collision is served as a write.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (owner)
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        dwait    = ~d_done;
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        iwait   = ~i_done;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against an owner model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int MAX_D = 8;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, ram_err;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: 0 = nobody owns the RAM, 1 = dcache, 2 = icache
  int m_owner = 0;
  int m_streak = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.MAX_DGRANTS(MAX_D)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
  );

  // Advance one clock; the model decides the next owner from the requests present at the edge.
  task automatic tick();
    bit dreq, done;
    int nxt, nstreak;
    dreq = dREN || dWEN;
    done = (m_owner != 0) && (ramstate == 2'd2);
    nstreak = m_streak;
    if (!iREN || (m_owner == 2 && done)) nstreak = 0;
    else if (m_owner == 1 && done) nstreak = m_streak + 1;
    if (m_owner == 1 && dreq)
      nxt = (FAIR && done && iREN && (m_streak + 1 >= MAX_D)) ? 2 : 1;
    else if (m_owner == 2 && iREN)
      nxt = (done && dreq) ? 1 : 2;
    else
      nxt = dreq ? 1 : (iREN ? 2 : 0);
    @(posedge CLK);
    #1;
    if (nRST) begin
      m_owner = nxt;
      m_streak = nstreak;
    end else begin
      m_owner = 0;
      m_streak = 0;
    end
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
  endtask

  task automatic test_reset();
    logic [132:0] got;
    idle_inputs();
    nRST = 0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    got = {ramREN, ramWEN, ramaddr, ramstore, iload, dload, iwait, dwait, ram_err};
    tests_run++;
    if (got !== {2'b00, 128'd0, 3'b110}) begin
      tests_failed++; $display("FAIL reset_values got=%h want=%h", got, {2'b00, 128'd0, 3'b110});
    end
    nRST = 1;
    m_owner = 0; m_streak = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      got = {ramREN, ramWEN, ramaddr, ramstore, iload, dload, iwait, dwait, ram_err};
      tests_run++;
      if (got !== {2'b00, 128'd0, 3'b110}) begin
        tests_failed++; $display("FAIL idle_hold cycle=%0d got=%h", c, got);
      end
      tick();
    end
  endtask

  task automatic test_iread();
    iREN = 1; iaddr = 32'h40; ramstate = 2'd0;
    @(negedge CLK);
    tests_run++;
    if (ramREN !== 1'b0 || iwait !== 1'b1) begin
      tests_failed++; $display("FAIL iread_idle_cycle ramREN=%b iwait=%b want 0/1", ramREN, iwait);
    end
    tick();
    ramstate = 2'd1;
    @(negedge CLK);
    tests_run++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1) begin
      tests_failed++; $display("FAIL iread_grant ramREN=%b ramaddr=%h iwait=%b want 1/00000040/1", ramREN, ramaddr, iwait);
    end
    tick();
    ramstate = 2'd2; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    tests_run++;
    if (iload !== 32'hDEADBEEF || iwait !== 1'b0) begin
      tests_failed++; $display("FAIL iread_complete iload=%h iwait=%b want deadbeef/0", iload, iwait);
    end
    iREN = 0;
    tick();
    ramstate = 2'd0;
    @(negedge CLK);
    tests_run++;
    if (iwait !== 1'b1 || ramREN !== 1'b0) begin
      tests_failed++; $display("FAIL iread_after iwait=%b ramREN=%b want 1/0", iwait, ramREN);
    end
    tick();
  endtask

  task automatic test_priority();
    iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h1234; ramstate = 2'd0;
    tick();
    ramstate = 2'd2;
    @(negedge CLK);
    tests_run++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h1234 || ramaddr !== 32'h80 ||
        dwait !== 1'b0 || iwait !== 1'b1) begin
      tests_failed++;
      $display("FAIL prio_dgrant ramWEN=%b ramREN=%b ramstore=%h ramaddr=%h dwait=%b iwait=%b want 1/0/1234/80/0/1",
               ramWEN, ramREN, ramstore, ramaddr, dwait, iwait);
    end
    dWEN = 0;
    tick();
    ramstate = 2'd1;
    @(negedge CLK);
    tests_run++;
    if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h44 || dwait !== 1'b1) begin
      tests_failed++;
      $display("FAIL prio_handoff ramREN=%b ramWEN=%b ramaddr=%h dwait=%b want 1/0/44/1", ramREN, ramWEN, ramaddr, dwait);
    end
    tick();
    ramstate = 2'd2; ramload = 32'hCAFE0001;
    @(negedge CLK);
    tests_run++;
    if (iwait !== 1'b0 || iload !== 32'hCAFE0001) begin
      tests_failed++; $display("FAIL prio_icomplete iwait=%b iload=%h want 0/cafe0001", iwait, iload);
    end
    iREN = 0;
    tick();
    ramstate = 2'd0;
    tick();
  endtask

  task automatic test_fairness();
    int dc = 0, ic = 0, ic_at8 = 0, cyc = 0;
    iREN = 1; iaddr = 32'h48; dWEN = 1; daddr = 32'h1000; dstore = 32'h0; ramstate = 2'd2;
    while (dc < 16 && cyc < 60) begin
      @(negedge CLK);
      if (dwait === 1'b0) begin
        dc++;
        daddr = daddr + 32'd4;
        dstore = dstore + 32'd1;
      end
      if (iwait === 1'b0) begin
        ic++;
        if (dc == MAX_D) ic_at8++;
      end
      tick();
      cyc++;
    end
    tests_run++;
    if (dc != 16) begin
      tests_failed++; $display("FAIL fair_timeout dcache_completions=%0d want 16", dc);
    end
    tests_run++;
    if (ic != (FAIR ? 1 : 0)) begin
      tests_failed++; $display("FAIL fair_icount got=%0d want=%0d", ic, FAIR ? 1 : 0);
    end
    tests_run++;
    if (ic_at8 != ic) begin
      tests_failed++; $display("FAIL fair_position icache_after_8th=%0d total=%0d", ic_at8, ic);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [132:0] got, exp;
    int r;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) iREN = ~iREN;
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 5);
        dREN = (r == 1) || (r == 3);
        dWEN = (r == 2) || (r == 3);
      end
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      ramstate = 2'($urandom_range(0, 2));
      @(negedge CLK);
      if (m_owner == 1)
        exp = {dREN && !dWEN, dWEN, daddr, dstore, 32'd0, ramload, 1'b1, ramstate != 2'd2, 1'b0};
      else if (m_owner == 2)
        exp = {iREN, 1'b0, iaddr, 32'd0, ramload, 32'd0, ramstate != 2'd2, 1'b1, 1'b0};
      else
        exp = {2'b00, 128'd0, 3'b110};
      got = {ramREN, ramWEN, ramaddr, ramstore, iload, dload, iwait, dwait, ram_err};
      tests_run++;
      if (got !== exp) begin
        tests_failed++; $display("FAIL random cycle=%0d owner=%0d got=%h want=%h", c, m_owner, got, exp);
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_error();
    dREN = 1; daddr = 32'h100; ramstate = 2'd0;
    tick();
    for (int c = 0; c < 3; c++) begin
      ramstate = 2'd3;
      @(negedge CLK);
      tests_run++;
      if (dwait !== 1'b1) begin
        tests_failed++; $display("FAIL err_wait cycle=%0d dwait=%b want 1", c, dwait);
      end
      tick();
    end
    ramstate = 2'd2; ramload = 32'hA5A5A5A5;
    @(negedge CLK);
    tests_run++;
    if (dwait !== 1'b0 || dload !== 32'hA5A5A5A5 || ram_err !== 1'b1) begin
      tests_failed++; $display("FAIL err_complete dwait=%b dload=%h ram_err=%b want 0/a5a5a5a5/1", dwait, dload, ram_err);
    end
    dREN = 0;
    tick();
    ramstate = 2'd0;
    @(negedge CLK);
    tests_run++;
    if (ram_err !== 1'b1) begin
      tests_failed++; $display("FAIL err_sticky ram_err=%b want 1", ram_err);
    end
    tick();
  endtask

  task automatic test_async_reset();
    dWEN = 1; daddr = 32'h300; dstore = 32'h77; ramstate = 2'd0;
    tick();
    ramstate = 2'd1;
    @(negedge CLK);
    tests_run++;
    if (ramWEN !== 1'b1) begin
      tests_failed++; $display("FAIL arst_pre ramWEN=%b want 1", ramWEN);
    end
    #2 nRST = 0;
    #1;
    tests_run++;
    if (ramWEN !== 1'b0 || dwait !== 1'b1 || ramaddr !== 32'h0 || ramstore !== 32'h0 || ram_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL arst_immediate ramWEN=%b dwait=%b ramaddr=%h ramstore=%h ram_err=%b want 0/1/0/0/0",
               ramWEN, dwait, ramaddr, ramstore, ram_err);
    end
    idle_inputs();
    tick();
    nRST = 1;
    dREN = 1; daddr = 32'h200;
    @(negedge CLK);
    tests_run++;
    if (ramREN !== 1'b0) begin
      tests_failed++; $display("FAIL arst_idle ramREN=%b want 0", ramREN);
    end
    tick();
    ramstate = 2'd2; ramload = 32'h11112222;
    @(negedge CLK);
    tests_run++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h200 || dwait !== 1'b0 || dload !== 32'h11112222) begin
      tests_failed++;
      $display("FAIL arst_regrant ramREN=%b ramaddr=%h dwait=%b dload=%h want 1/200/0/11112222", ramREN, ramaddr, dwait, dload);
    end
    dREN = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_iread();
    test_priority();
    test_fairness();
    test_random();
    test_error();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter between the instruction cache, the data cache and the single-ported RAM. It takes word requests from the icache (read-only) and the dcache (read, write-back, halt flush), grants the RAM port to one of them at a time, and returns load data with a per-requester wait. The dcache has priority. An optional fairness counter stops icache starvation during long dcache write-back/flush bursts.

## Interface
Parameters:
- MAX_DGRANTS, 8: max consecutive dcache word completions while iREN pending (used only with fairness enabled)

Ports:
- CLK  in  1  system clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iload  out  32  icache read data
- iwait  out  1  icache stall; low for exactly the completing cycle
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dload  out  32  dcache read data
- dwait  out  1  dcache stall; low for exactly the completing cycle
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- ram_err  out  1  sticky; set on any cycle ramstate==ERROR while owner active

## Operation
- Owner register states: IDLE, DGRANT, IGRANT. RAM outputs are driven combinationally from the registered owner.
- IDLE: next owner is DGRANT if dREN|dWEN, else IGRANT if iREN, else IDLE.
- DGRANT: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore. dREN&dWEN together is illegal. The arbiter treats it as a write (ramREN forced 0).
- IGRANT: ramREN=iREN, ramWEN=0, ramaddr=iaddr, ramstore=0.
- Completion is a cycle with owner active and ramstate==ACCESS. The owner's wait is low that cycle. dload/iload=ramload, passed through combinationally.
- Handoff: re-evaluated every cycle:
  - If the current owner's request has dropped, the next owner is chosen by the IDLE rule.
  - DGRANT with dREN|dWEN still high stays DGRANT.
  - IGRANT with iREN still high: moves to DGRANT after a completion if the dcache is requesting, otherwise stays.
- Non-owner outputs: wait=1. iload/dload read 0 when not owner.
- ERROR: no completion, wait stays high, ram_err sets. Only reset clears ram_err.

## Timing
- Reset values: owner=IDLE, iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0, ram_err=0, fairness counter=0.
- A request seen in IDLE is granted from the next cycle. Minimum latency from request to completion is 1 cycle plus the RAM latency.
- An owner that drops its request on its completing cycle hands off that same edge: a pending requester is owner on the next cycle, with no IDLE bubble.
- A requester dropping its request mid-access (no completion) loses the grant next cycle. The RAM sees the enables fall that cycle.
- Asynchronous reset mid-access aborts immediately: all outputs go to reset values without waiting for the clock.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - A 4-bit counter increments on each dcache completion while iREN=1. It clears on any icache completion or when iREN=0.
  - When it reaches MAX_DGRANTS, the next owner after the current dcache completion is IGRANT. This holds even if the dcache is still requesting.
  - After one icache completion, dcache priority resumes.
- MEM_ARB_FAIR_EN undefined:
  - No counter. The dcache always wins, so the icache can starve during a flush.

## Test plan
- Reset, then idle: all outputs at reset values, iwait=dwait=1, owner stays IDLE with no requests.
- iREN with iaddr=0x40, ramstate ACCESS on the 2nd cycle after the grant, ramload=0xDEADBEEF:
  - iload=0xDEADBEEF and iwait=0 for one cycle.
  - ramREN=1, ramaddr=0x40 during the grant.
- iREN and dWEN raised on the same cycle (daddr=0x80, dstore=0x1234):
  - dcache granted first; ramWEN=1, ramstore=0x1234.
  - After dWEN drops on the completion, IGRANT follows on the next cycle with no bubble.
- Fairness, with MEM_ARB_FAIR_EN and MAX_DGRANTS=8: dcache holds dWEN through 16 word completions while iREN is held.
  - Exactly one icache completion after the 8th dcache completion.
  - Without the macro, iwait stays 1 for all 16 completions.
- ramstate=ERROR for 3 cycles during DGRANT, then ACCESS:
  - dwait stays 1 through the error cycles.
  - ram_err=1 and stays set after completion.
- nRST asserted mid-burst with ramWEN=1:
  - ramWEN=0 and owner=IDLE immediately.
  - After release, a new dREN is granted cleanly.
